ahb_lite_interconnect_n: RTL and testbench
==========================================

Name: ahb_lite_interconnect_n

Overview:
- Parametrised AHB-Lite single-manager interconnect: address decoder, registered data-phase response mux and built-in default subordinate, sized for NO_OF_SUBORDINATES external subordinates.
- Replaces the fixed six-slot decoder/mux/default-subordinate trio. Sits between the manager and the subordinates.
- Address/control/HWDATA are broadcast to subordinates by top-level wiring. This block generates HSEL, the global HREADY and the muxed response.

Parameters:
NO_OF_SUBORDINATES, 4, number of external subordinates (1..31)
BITS_FOR_SUBORDINATES, 5, decode field width = HADDR[ADDR_WIDTH-1 -: BITS_FOR_SUBORDINATES]
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
TIMEOUT_CYCLES, 16, wait-state limit, used only with AHB_IC_TIMEOUT_EN

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
HADDR  in  ADDR_WIDTH  manager address
HTRANS  in  2  manager transfer type
HRDATA  out  DATA_WIDTH  muxed read data to manager
HRESP  out  2  muxed response (00 OKAY, 01 ERROR)
HREADY  out  1  global HREADY; also fed back to subordinates as HREADYin
HSEL_S  out  NO_OF_SUBORDINATES  one-hot address-phase selects
HRDATA_S  in  NO_OF_SUBORDINATES*DATA_WIDTH  subordinate read data, flattened, sub i at [i*DATA_WIDTH +: DATA_WIDTH]
HRESP_S  in  NO_OF_SUBORDINATES*2  subordinate responses, flattened
HREADYOUT_S  in  NO_OF_SUBORDINATES  subordinate ready outputs
TIMEOUT_IRQ  out  1  sticky timeout flag; tied 0 without the macro

Behaviour:
- Decode (combinational):
  - field = top BITS_FOR_SUBORDINATES bits of HADDR.
  - HSEL_S[field]=1 when field < NO_OF_SUBORDINATES; otherwise the default subordinate is selected and HSEL_S=0.
  - Decode is independent of HTRANS and HREADY.
- Data-phase select sel_q:
  - One-hot, NO_OF_SUBORDINATES+1 bits; the top bit is the default subordinate.
  - Loads the current decode on a rising HCLK edge only when HREADY=1.
  - trans_q = HTRANS[1] is loaded under the same condition.
- Response mux (combinational from sel_q): HRDATA/HRESP/HREADY taken from the selected source. The default subordinate returns HRDATA=0.
- Default subordinate FSM (DS_IDLE, DS_ERR1, DS_ERR2):
  - DS_IDLE: outputs ready=1, OKAY. Goes to DS_ERR1 when HREADY=1, default decoded and HTRANS is NONSEQ or SEQ.
  - DS_ERR1: outputs ready=0, ERROR. Goes unconditionally to DS_ERR2.
  - DS_ERR2: outputs ready=1, ERROR. Goes to DS_ERR1 if another active transfer decodes to default this cycle, else to DS_IDLE.
  - IDLE/BUSY transfers to default get a zero-wait OKAY.
- Latency: decode to HSEL_S is 0 cycles. Response appears in the data phase, one cycle after address acceptance, plus subordinate wait states.
- Back-to-back: while the data-phase subordinate stalls, HSEL_S follows the new address, but sel_q holds until HREADY=1.
- Reset (async, immediate):
  - sel_q = default, FSM = DS_IDLE, trans_q=0, counter=0, TIMEOUT_IRQ=0.
  - Outputs are therefore HREADY=1, HRESP=00, HRDATA=0.
  - Mid-transfer reset abandons the transfer; no response is completed.
- HRESP_S codes other than 00/01 are passed through unchanged.

Optional Feature:
- Macro: AHB_IC_TIMEOUT_EN.
- With the macro:
  - A counter increments each cycle that trans_q=1, an external subordinate is in sel_q and its HREADYOUT=0. It clears whenever HREADY=1.
  - When the counter reaches TIMEOUT_CYCLES, the block overrides the mux: one cycle HREADY=0/ERROR, then one cycle HREADY=1/ERROR.
  - The stalled subordinate's outputs are ignored during the override.
  - TIMEOUT_IRQ sets and stays high until reset.
- Without the macro: no counter is built, TIMEOUT_IRQ=0, and a stalled subordinate stalls the bus indefinitely.

Decomposition:
- Package ahb_ic_pkg: htrans_t (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11), HRESP_OKAY/HRESP_ERROR constants, ds_state_t.
- Sub-module ahb_ic_default_sub holds the default subordinate FSM. Its inputs are HCLK, HRESETn, sel, HTRANS and HREADY; its outputs are ready and resp.

Test Plan:
- Reset with HADDR=0xF800_0000 -> HSEL_S=0000, HREADY=1, HRESP=00, HRDATA=0, TIMEOUT_IRQ=0.
- NONSEQ read at 0x0800_0000 -> HSEL_S=0010. In the data phase sub1 gives 2 wait cycles then HRDATA_S=0xCAFE_F00D; HREADY is 0,0,1 and HRDATA=0xCAFE_F00D with HRESP=00.
- NONSEQ at 0xF800_0000 -> data phase HREADY=0/HRESP=01, then HREADY=1/HRESP=01, then OKAY. A second NONSEQ to default during ERR2 -> the ERROR pair repeats with no idle cycle.
- Read sub0 (3 wait states) then read at 0x1000_0000 -> HSEL_S=0100 during the stall, sel_q stays sub0 until HREADY=1, then sub2 data is returned.
- IDLE transfer to 0xF800_0000 -> HREADY=1, HRESP=00 with no wait states.
- Macro on, TIMEOUT_CYCLES=16, sub3 holds HREADYOUT=0 -> after 16 low cycles HREADY=0/01 then 1/01, and TIMEOUT_IRQ=1 until reset. Macro off -> HREADY stays 0.

Source files
------------

// File: rtl/ahb_ic_pkg.sv
// Shared types for the AHB-Lite N-subordinate interconnect.
// Optional wait-state timeout is enabled with AHB_IC_TIMEOUT_EN.
package ahb_ic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_t;

  function automatic logic is_active(
    input logic [1:0] t
  );
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_ic_default_sub.sv
// Built-in default subordinate: zero-wait OKAY for IDLE/BUSY,
// two-cycle ERROR response for active transfers to unmapped space.
module ahb_ic_default_sub
  import ahb_ic_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       sel,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       ready,
  output logic [1:0] resp
);

  ds_state_t state_q, state_d;
  logic      start;

  assign start = HREADY && sel && is_active(HTRANS);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= DS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b1;
    resp    = HRESP_OKAY;
    unique case (state_q)
      DS_IDLE: begin
        if (start) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        ready   = 1'b0;
        resp    = HRESP_ERROR;
        state_d = DS_ERR2;
      end
      DS_ERR2: begin
        resp    = HRESP_ERROR;
        state_d = start ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_lite_interconnect_n.sv
// AHB-Lite single-manager decoder, data-phase mux and default sub.
// Define AHB_IC_TIMEOUT_EN to build the wait-state timeout.
module ahb_lite_interconnect_n
  import ahb_ic_pkg::*;
#(
  parameter int NO_OF_SUBORDINATES    = 4,
  parameter int BITS_FOR_SUBORDINATES = 5,
  parameter int ADDR_WIDTH            = 32,
  parameter int DATA_WIDTH            = 32,
  parameter int TIMEOUT_CYCLES        = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic [1:0]              HRESP,
  output logic                    HREADY,
  output logic [NO_OF_SUBORDINATES-1:0] HSEL_S,
  input  logic [NO_OF_SUBORDINATES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NO_OF_SUBORDINATES*2-1:0] HRESP_S,
  input  logic [NO_OF_SUBORDINATES-1:0] HREADYOUT_S,
  output logic                    TIMEOUT_IRQ
);

  localparam int NS = NO_OF_SUBORDINATES;
  localparam int BS = BITS_FOR_SUBORDINATES;

  logic [BS-1:0]         field;
  logic [NS:0]           dec;
  logic [NS:0]           sel_q;
  logic [DATA_WIDTH-1:0] mux_rdata;
  logic [1:0]            mux_resp;
  logic                  mux_ready;
  logic                  ds_ready;
  logic [1:0]            ds_resp;
  logic                  unused_addr;

  assign field       = HADDR[ADDR_WIDTH-1 -: BS];
  assign unused_addr = ^HADDR[ADDR_WIDTH-BS-1:0];

  // Top bit of dec/sel_q is the default subordinate.
  always_comb begin
    dec = '0;
    for (int i = 0; i < NS; i++) begin
      dec[i] = (32'(field) == 32'(i));
    end
    dec[NS] = (32'(field) >= 32'(NS));
  end

  assign HSEL_S = dec[NS-1:0];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    sel_q <= {1'b1, {NS{1'b0}}};
    else if (HREADY) sel_q <= dec;
  end

  ahb_ic_default_sub u_ds (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .sel     (dec[NS]),
    .HTRANS  (HTRANS),
    .HREADY  (HREADY),
    .ready   (ds_ready),
    .resp    (ds_resp)
  );

  always_comb begin
    mux_rdata = '0;
    mux_resp  = HRESP_OKAY;
    mux_ready = 1'b1;
    for (int i = 0; i < NS; i++) begin
      if (sel_q[i]) begin
        mux_rdata = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        mux_resp  = HRESP_S[i*2 +: 2];
        mux_ready = HREADYOUT_S[i];
      end
    end
    if (sel_q[NS]) begin
      mux_rdata = '0;
      mux_resp  = ds_resp;
      mux_ready = ds_ready;
    end
  end

`ifdef AHB_IC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          trans_q;
  logic          to_err2_q;
  logic          irq_q;
  logic          to_err1;
  logic          stall;

  assign stall   = trans_q && !sel_q[NS] && !mux_ready;
  assign to_err1 = (cnt_q == CW'(TIMEOUT_CYCLES)) && !to_err2_q;

  always_comb begin
    cnt_d = cnt_q;
    if (HREADY)                cnt_d = '0;
    else if (stall && !to_err1) cnt_d = cnt_q + CW'(1);
  end

  // Override: ERROR with HREADY low, then ERROR with HREADY high.
  assign HREADY = to_err2_q || (!to_err1 && mux_ready);
  assign HRESP  = (to_err1 || to_err2_q) ? HRESP_ERROR : mux_resp;
  assign HRDATA = (to_err1 || to_err2_q) ? '0 : mux_rdata;
  assign TIMEOUT_IRQ = irq_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q     <= '0;
      trans_q   <= 1'b0;
      to_err2_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      to_err2_q <= to_err1;
      if (HREADY) trans_q <= HTRANS[1];
      if (to_err1) irq_q <= 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign HREADY      = mux_ready;
  assign HRESP       = mux_resp;
  assign HRDATA      = mux_rdata;
  assign TIMEOUT_IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_lite_interconnect_n.sv
// Scoreboard bench for ahb_lite_interconnect_n (4 subordinates).
// Timeout scenario adapts to AHB_IC_TIMEOUT_EN.
module tb_ahb_lite_interconnect_n;
  import ahb_ic_pkg::*;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b1;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic [31:0]  HRDATA;
  logic [1:0]   HRESP;
  logic         HREADY;
  logic [3:0]   HSEL_S;
  logic [127:0] HRDATA_S;
  logic [7:0]   HRESP_S;
  logic [3:0]   HREADYOUT_S;
  logic         TIMEOUT_IRQ;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  ahb_lite_interconnect_n dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HRDATA      (HRDATA),
    .HRESP       (HRESP),
    .HREADY      (HREADY),
    .HSEL_S      (HSEL_S),
    .HRDATA_S    (HRDATA_S),
    .HRESP_S     (HRESP_S),
    .HREADYOUT_S (HREADYOUT_S),
    .TIMEOUT_IRQ (TIMEOUT_IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HADDR       = 32'hF800_0000;
    HTRANS      = IDLE;
    HRDATA_S    = '0;
    HRESP_S     = '0;
    HREADYOUT_S = 4'hF;
    #1 HRESETn = 1'b0;
    #2;
    total++;
    if (HSEL_S !== 4'b0000 || HREADY !== 1'b1 ||
        HRESP !== 2'b00 || HRDATA !== 32'h0 ||
        TIMEOUT_IRQ !== 1'b0)
      $display("FAIL reset: sel=%b rdy=%b resp=%b d=%h irq=%b want 0000/1/00/0/0",
               HSEL_S, HREADY, HRESP, HRDATA, TIMEOUT_IRQ);
    else passed++;
    step();
    HRESETn = 1'b1;
  endtask

  task automatic test_read_wait();
    step();
    HADDR  = 32'h0800_0000;
    HTRANS = NONSEQ;
    #1;
    total++;
    if (HSEL_S !== 4'b0010)
      $display("FAIL rd_hsel: got %b want 0010", HSEL_S);
    else passed++;
    sb.push_back('{32'hCAFE_F00D, HRESP_OKAY});
    step();
    HTRANS = IDLE;
    HADDR  = 32'h0;
    HREADYOUT_S[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) step();
      #1;
      total++;
      if (HREADY !== 1'b0)
        $display("FAIL rd_wait%0d: HREADY got %b want 0", i, HREADY);
      else passed++;
    end
    step();
    HREADYOUT_S[1] = 1'b1;
    HRDATA_S[63:32] = 32'hCAFE_F00D;
    #1;
    e = sb.pop_front();
    total++;
    if (HREADY !== 1'b1 || HRDATA !== e.data || HRESP !== e.resp)
      $display("FAIL rd_data: got %b/%h/%b want 1/%h/%b",
               HREADY, HRDATA, HRESP, e.data, e.resp);
    else passed++;
    step();
    HRDATA_S[63:32] = 32'h0;
  endtask

  task automatic test_default_err();
    step();
    HADDR  = 32'hF800_0000;
    HTRANS = NONSEQ;
    #1;
    total++;
    if (HSEL_S !== 4'b0000)
      $display("FAIL def_hsel: got %b want 0000", HSEL_S);
    else passed++;
    sb.push_back('{32'h0, HRESP_ERROR});
    step();
    HTRANS = IDLE;
    #1;
    total++;
    if (HREADY !== 1'b0 || HRESP !== HRESP_ERROR)
      $display("FAIL def_err1a: got %b/%b want 0/01", HREADY, HRESP);
    else passed++;
    step();
    HTRANS = NONSEQ;
    #1;
    e = sb.pop_front();
    total++;
    if (HREADY !== 1'b1 || HRDATA !== e.data || HRESP !== e.resp)
      $display("FAIL def_err2a: got %b/%h/%b want 1/%h/%b",
               HREADY, HRDATA, HRESP, e.data, e.resp);
    else passed++;
    sb.push_back('{32'h0, HRESP_ERROR});
    step();
    HTRANS = IDLE;
    #1;
    total++;
    if (HREADY !== 1'b0 || HRESP !== HRESP_ERROR)
      $display("FAIL def_err1b: got %b/%b want 0/01", HREADY, HRESP);
    else passed++;
    step();
    #1;
    e = sb.pop_front();
    total++;
    if (HREADY !== 1'b1 || HRDATA !== e.data || HRESP !== e.resp)
      $display("FAIL def_err2b: got %b/%h/%b want 1/%h/%b",
               HREADY, HRDATA, HRESP, e.data, e.resp);
    else passed++;
    step();
    #1;
    total++;
    if (HREADY !== 1'b1 || HRESP !== HRESP_OKAY)
      $display("FAIL def_okay: got %b/%b want 1/00", HREADY, HRESP);
    else passed++;
  endtask

  task automatic test_back_to_back();
    HRDATA_S[31:0]  = 32'hA0A0_A0A0;
    HRDATA_S[95:64] = 32'hB2B2_B2B2;
    HRESP_S[5:4]    = 2'b10;
    step();
    HADDR  = 32'h0000_0000;
    HTRANS = NONSEQ;
    #1;
    total++;
    if (HSEL_S !== 4'b0001)
      $display("FAIL b2b_hsel0: got %b want 0001", HSEL_S);
    else passed++;
    sb.push_back('{32'hA0A0_A0A0, HRESP_OKAY});
    step();
    HADDR = 32'h1000_0000;
    HREADYOUT_S[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #1;
      total++;
      if (HSEL_S !== 4'b0100 || HREADY !== 1'b0 ||
          HRDATA !== 32'hA0A0_A0A0)
        $display("FAIL b2b_stall%0d: got %b/%b/%h want 0100/0/a0a0a0a0",
                 i, HSEL_S, HREADY, HRDATA);
      else passed++;
    end
    step();
    HREADYOUT_S[0] = 1'b1;
    #1;
    e = sb.pop_front();
    total++;
    if (HREADY !== 1'b1 || HRDATA !== e.data || HRESP !== e.resp)
      $display("FAIL b2b_sub0: got %b/%h/%b want 1/%h/%b",
               HREADY, HRDATA, HRESP, e.data, e.resp);
    else passed++;
    sb.push_back('{32'hB2B2_B2B2, 2'b10});
    step();
    HTRANS = IDLE;
    #1;
    e = sb.pop_front();
    total++;
    if (HREADY !== 1'b1 || HRDATA !== e.data || HRESP !== e.resp)
      $display("FAIL b2b_sub2: got %b/%h/%b want 1/%h/%b",
               HREADY, HRDATA, HRESP, e.data, e.resp);
    else passed++;
    HRESP_S = '0;
  endtask

  task automatic test_idle_default();
    step();
    HADDR  = 32'h2000_0000;
    HTRANS = NONSEQ;
    #1;
    total++;
    if (HSEL_S !== 4'b0000)
      $display("FAIL dec_edge4: got %b want 0000", HSEL_S);
    else passed++;
    HADDR = 32'h1800_0000;
    #1;
    total++;
    if (HSEL_S !== 4'b1000)
      $display("FAIL dec_edge3: got %b want 1000", HSEL_S);
    else passed++;
    HADDR  = 32'hF800_0000;
    HTRANS = IDLE;
    step();
    HTRANS = BUSY;
    #1;
    total++;
    if (HREADY !== 1'b1 || HRESP !== HRESP_OKAY)
      $display("FAIL idle_def: got %b/%b want 1/00", HREADY, HRESP);
    else passed++;
    step();
    HTRANS = IDLE;
    #1;
    total++;
    if (HREADY !== 1'b1 || HRESP !== HRESP_OKAY)
      $display("FAIL busy_def: got %b/%b want 1/00", HREADY, HRESP);
    else passed++;
  endtask

  task automatic test_timeout();
    logic bad;
    HRDATA_S[127:96] = 32'h5555_AAAA;
    step();
    HADDR  = 32'h1800_0000;
    HTRANS = NONSEQ;
    #1;
    total++;
    if (HSEL_S !== 4'b1000)
      $display("FAIL to_hsel: got %b want 1000", HSEL_S);
    else passed++;
`ifdef AHB_IC_TIMEOUT_EN
    sb.push_back('{32'h0, HRESP_ERROR});
    step();
    HTRANS = IDLE;
    HADDR  = 32'h0;
    HREADYOUT_S[3] = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      #1;
      if (HREADY !== 1'b0 || HRESP !== HRESP_OKAY) bad = 1'b1;
    end
    total++;
    if (bad)
      $display("FAIL to_stall16: early override, last %b/%b want 0/00",
               HREADY, HRESP);
    else passed++;
    step();
    #1;
    total++;
    if (HREADY !== 1'b0 || HRESP !== HRESP_ERROR)
      $display("FAIL to_err1: got %b/%b want 0/01", HREADY, HRESP);
    else passed++;
    step();
    #1;
    e = sb.pop_front();
    total++;
    if (HREADY !== 1'b1 || HRDATA !== e.data || HRESP !== e.resp)
      $display("FAIL to_err2: got %b/%h/%b want 1/%h/%b",
               HREADY, HRDATA, HRESP, e.data, e.resp);
    else passed++;
    step();
    step();
    #1;
    total++;
    if (TIMEOUT_IRQ !== 1'b1 || HREADY !== 1'b1)
      $display("FAIL to_irq: got irq=%b rdy=%b want 1/1",
               TIMEOUT_IRQ, HREADY);
    else passed++;
`else
    sb.push_back('{32'h5555_AAAA, HRESP_OKAY});
    step();
    HTRANS = IDLE;
    HADDR  = 32'h0;
    HREADYOUT_S[3] = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) step();
      #1;
      if (HREADY !== 1'b0 || TIMEOUT_IRQ !== 1'b0) bad = 1'b1;
    end
    total++;
    if (bad)
      $display("FAIL no_to_stall: got rdy=%b irq=%b want 0/0",
               HREADY, TIMEOUT_IRQ);
    else passed++;
    step();
    HREADYOUT_S[3] = 1'b1;
    #1;
    e = sb.pop_front();
    total++;
    if (HREADY !== 1'b1 || HRDATA !== e.data || HRESP !== e.resp)
      $display("FAIL no_to_done: got %b/%h/%b want 1/%h/%b",
               HREADY, HRDATA, HRESP, e.data, e.resp);
    else passed++;
`endif
    HREADYOUT_S[3] = 1'b1;
    HRDATA_S[127:96] = 32'h0;
  endtask

  task automatic test_mid_reset();
    step();
    HADDR  = 32'h0800_0000;
    HTRANS = NONSEQ;
    step();
    HTRANS = IDLE;
    HREADYOUT_S[1] = 1'b0;
    HRDATA_S[63:32] = 32'hDEAD_BEEF;
    #1;
    total++;
    if (HREADY !== 1'b0 || HRDATA !== 32'hDEAD_BEEF)
      $display("FAIL mr_stall: got %b/%h want 0/deadbeef",
               HREADY, HRDATA);
    else passed++;
    #1 HRESETn = 1'b0;
    #1;
    total++;
    if (HREADY !== 1'b1 || HRDATA !== 32'h0 ||
        HRESP !== 2'b00 || TIMEOUT_IRQ !== 1'b0)
      $display("FAIL mr_async: got %b/%h/%b irq=%b want 1/0/00/0",
               HREADY, HRDATA, HRESP, TIMEOUT_IRQ);
    else passed++;
    step();
    HRESETn = 1'b1;
    HREADYOUT_S[1] = 1'b1;
    HRDATA_S[63:32] = 32'h0;
    total++;
    if (sb.size() != 0)
      $display("FAIL sb_empty: got %0d left want 0", sb.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_read_wait();
    test_default_err();
    test_back_to_back();
    test_idle_default();
    test_timeout();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
